attitude_led_driver: RTL and testbench
======================================

// Module: attitude_led_driver
// PURPOSE
//  Downstream consumer of the 4-bit roll/pitch attitude code {sgn(roll), sgn(pitch), over(roll), over(pitch)}.
//  Debounces the attitude code across STABLE_SAMPLES consecutive valid samples.
//  Flags stale input when no sample arrives within a timeout.
//  Drives five board indicator LEDs: level plus four tilt directions.
// PARAMETERS
//  STABLE_SAMPLES     4           consecutive identical valid samples required to commit (>=1)
//  SAMPLE_TIMEOUT     10_000_000  clocks without i_Valid before entering STALE (>=2)
//  BLINK_HALF_PERIOD  25_000_000  clocks per blink phase; used only when blink is compiled in
// PORTS
//  i_Clk               in   1  system clock
//  i_Rst               in   1  synchronous reset, active-high
//  i_Attitude          in   4  [3] roll neg, [2] pitch neg, [1] roll over thr, [0] pitch over thr
//  i_Valid             in   1  one-cycle strobe; i_Attitude is sampled on that cycle
//  o_Attitude_Stable   out  4  last committed attitude code
//  o_Stable_Valid      out  1  one-cycle pulse when o_Attitude_Stable is (re)committed with a new value
//  o_Stale             out  1  1 in NO_DATA and STALE states
//  o_Led               out  5  [4] level, [3] roll pos, [2] roll neg, [1] pitch pos, [0] pitch neg
// BEHAVIOUR
//  Reset (sync, active-high, i_Clk edge):
//   - state=NO_DATA; candidate=0; match count=0; timer=0.
//   - o_Attitude_Stable=0, o_Stable_Valid=0, o_Stale=1, o_Led=0.
//   - Reset asserted mid-operation discards candidate and committed values identically.
//  Debounce: on each i_Valid cycle:
//   - sample==candidate -> count=min(count+1, STABLE_SAMPLES).
//   - sample differs -> candidate=sample, count=1.
//   - When the accepted sample makes count==STABLE_SAMPLES, commit on that edge.
//   - Commit means o_Attitude_Stable<=candidate.
//   - o_Stable_Valid pulses on that edge only if the value differs from the previous commit, or on the first commit after NO_DATA/STALE.
//   - Further identical samples never re-pulse.
//  Latency: o_Attitude_Stable updates 1 clk after the STABLE_SAMPLES-th matching i_Valid; o_Led follows 1 clk later (registered).
//  FSM:
//   - NO_DATA -> LOCKED on first commit.
//   - LOCKED -> STALE when timer reaches SAMPLE_TIMEOUT-1 with no i_Valid.
//   - STALE -> LOCKED on next commit.
//   - Entering STALE clears count to 0, so a fresh STABLE_SAMPLES run is required.
//   - o_Attitude_Stable holds its last value in STALE.
//  Timer: cleared on every i_Valid; otherwise increments; saturates in STALE. Simultaneous i_Valid and timeout: i_Valid wins, no STALE entry.
//  LED map (LOCKED only; all 0 in NO_DATA/STALE):
//   - [3]=over_r&~neg_r, [2]=over_r&neg_r, [1]=over_p&~neg_p, [0]=over_p&neg_p.
//   - [4]=~over_r&~over_p.
//   - A sign bit with its over bit 0 never lights a direction LED.
// CONFIGURATION
//  Macro ATTITUDE_LED_BLINK_EN:
//   - Defined: o_Led[3:0] are ANDed with a blink phase toggling every BLINK_HALF_PERIOD clocks.
//     - Phase=1 (on) out of reset and on each NO_DATA/STALE->LOCKED transition; counter restarts at 0.
//     - o_Led[4] stays steady.
//   - Undefined: o_Led[3:0] steady; blink counter and phase logic not instantiated; BLINK_HALF_PERIOD ignored.
// STRUCTURE
//  Package attitude_pkg:
//   - Attitude bit indices ATT_ROLL_SGN=3, ATT_PITCH_SGN=2, ATT_ROLL_OVR=1, ATT_PITCH_OVR=0.
//   - LED index constants LED_LEVEL..LED_PITCH_NEG.
//   - FSM encoding NO_DATA/LOCKED/STALE.
//  Sub-module attitude_debounce: candidate register, match counter, commit/pulse generation.
//  Top: FSM, timeout timer, LED map, optional blink.
// TESTING  (bench params: STABLE_SAMPLES=3, SAMPLE_TIMEOUT=20, BLINK_HALF_PERIOD=4)
//  1. Reset, then 3 valids of 4'b0000 -> o_Stable_Valid pulse once; o_Stale 1->0; o_Led=5'b10000 next clk.
//  2. Locked on 0000; send 1010,1010,0110,1010,1010,1010 -> commit only after the last three; o_Attitude_Stable=1010, o_Led=5'b00100.
//  3. Send 1100 x3 (signs set, under thr) -> o_Led=5'b10000; 4th identical valid -> no extra pulse.
//  4. Locked, then 20 clks idle -> o_Stale=1, o_Led=0, o_Attitude_Stable held. i_Valid on timeout clk -> stays LOCKED.
//  5. From STALE, 2 valids then i_Rst mid-run -> all outputs reset values; 3 fresh valids required to lock.
//  6. With ATTITUDE_LED_BLINK_EN, lock on 0011 -> o_Led[1:0]... o_Led[0],o_Led[1] per signs toggle every 4 clks starting on; o_Led[4]=0 steady.

Source files
------------

// File: rtl/attitude_pkg.sv
// attitude_pkg
//   Shared constants and types for the attitude LED driver.
//   - Attitude code bit positions
//   - Indicator LED bit positions
//   - FSM state encoding
//   - led_map(): converts an attitude code into the steady LED pattern
package attitude_pkg;

    localparam int unsigned ATT_ROLL_SGN  = 3;
    localparam int unsigned ATT_PITCH_SGN = 2;
    localparam int unsigned ATT_ROLL_OVR  = 1;
    localparam int unsigned ATT_PITCH_OVR = 0;

    localparam int unsigned LED_LEVEL     = 4;
    localparam int unsigned LED_ROLL_POS  = 3;
    localparam int unsigned LED_ROLL_NEG  = 2;
    localparam int unsigned LED_PITCH_POS = 1;
    localparam int unsigned LED_PITCH_NEG = 0;

    typedef enum logic [1:0] {
        NO_DATA = 2'd0,
        LOCKED  = 2'd1,
        STALE   = 2'd2
    } att_state_e;

    // A sign bit alone never lights a direction LED; only the over-threshold
    // bit qualifies it.
    function automatic logic [4:0] led_map(input logic [3:0] att);
        logic [4:0] led;
        led                = '0;
        led[LED_LEVEL]     = ~att[ATT_ROLL_OVR] & ~att[ATT_PITCH_OVR];
        led[LED_ROLL_POS]  =  att[ATT_ROLL_OVR]  & ~att[ATT_ROLL_SGN];
        led[LED_ROLL_NEG]  =  att[ATT_ROLL_OVR]  &  att[ATT_ROLL_SGN];
        led[LED_PITCH_POS] =  att[ATT_PITCH_OVR] & ~att[ATT_PITCH_SGN];
        led[LED_PITCH_NEG] =  att[ATT_PITCH_OVR] &  att[ATT_PITCH_SGN];
        return led;
    endfunction

endpackage

// File: rtl/attitude_debounce.sv
// attitude_debounce
//   Requires STABLE_SAMPLES consecutive identical valid samples before
//   committing the attitude code.
// Ports
//   clk_i           system clock
//   rst_i           synchronous reset, active-high
//   valid_i         sample strobe
//   sample_i[3:0]   attitude code sampled when valid_i is high
//   clear_i         zero the match count (used when the input goes stale)
//   force_pulse_i   pulse on the next commit even if the value is unchanged
//   stable_o[3:0]   last committed code
//   stable_valid_o  one-cycle registered pulse on a new commit
//   commit_o        combinational: a commit happens on this edge
module attitude_debounce
    import attitude_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [3:0] sample_i,
    input  logic       clear_i,
    input  logic       force_pulse_i,
    output logic [3:0] stable_o,
    output logic       stable_valid_o,
    output logic       commit_o
);

    localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SAMPLES);

    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic          match;
    logic          commit;

    always_comb begin
        match  = (sample_i == cand_q);
        cand_d = cand_q;
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end
        if (valid_i) begin
            if (match) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cand_d = sample_i;
                cnt_d  = CW'(1);
            end
            // Only the sample that first reaches the target commits; an
            // already-saturated run stays silent.
            commit = (cnt_d == CNT_MAX) && !(match && (cnt_q == CNT_MAX));
        end
        stable_d = commit ? sample_i : stable_q;
        pulse_d  = commit && ((sample_i != stable_q) || force_pulse_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    assign stable_o       = stable_q;
    assign stable_valid_o = pulse_q;
    assign commit_o       = commit;

endmodule

// File: rtl/attitude_led_driver.sv
// attitude_led_driver
//   Debounces the 4-bit roll/pitch attitude code, flags stale input and
//   drives five indicator LEDs (level + four tilt directions).
//   Build option: define ATTITUDE_LED_BLINK_EN to blink the four direction
//   LEDs with a BLINK_HALF_PERIOD-clock phase; otherwise they are steady.
// Ports
//   i_Clk                   system clock
//   i_Rst                   synchronous reset, active-high
//   i_Attitude[3:0]         {roll neg, pitch neg, roll over, pitch over}
//   i_Valid                 one-cycle sample strobe
//   o_Attitude_Stable[3:0]  last committed code
//   o_Stable_Valid          pulse on a new commit
//   o_Stale                 high while no locked data
//   o_Led[4:0]              {level, roll pos, roll neg, pitch pos, pitch neg}
//
// state   | meaning
// NO_DATA | nothing committed since reset
// LOCKED  | committed code is current, LEDs driven
// STALE   | no sample within SAMPLE_TIMEOUT, LEDs dark, code held
module attitude_led_driver
    import attitude_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES    = 4,
    parameter int unsigned SAMPLE_TIMEOUT    = 10_000_000,
    parameter int unsigned BLINK_HALF_PERIOD = 25_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Attitude,
    input  logic       i_Valid,
    output logic [3:0] o_Attitude_Stable,
    output logic       o_Stable_Valid,
    output logic       o_Stale,
    output logic [4:0] o_Led
);

    if (STABLE_SAMPLES < 1 || SAMPLE_TIMEOUT < 2 || BLINK_HALF_PERIOD < 1) begin : g_param_check
        $error("attitude_led_driver: illegal parameter value");
    end

    localparam int unsigned TW = $clog2(SAMPLE_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(SAMPLE_TIMEOUT - 1);

    att_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          stale_q;
    logic [4:0]    led_q, led_d;
    logic [3:0]    stable_w;
    logic          commit_w;
    logic          timeout_w;

    // i_Valid on the timeout cycle keeps the state LOCKED.
    assign timeout_w = (state_q == LOCKED) && !i_Valid && (timer_q == TMAX);

    attitude_debounce #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_debounce (
        .clk_i          (i_Clk),
        .rst_i          (i_Rst),
        .valid_i        (i_Valid),
        .sample_i       (i_Attitude),
        .clear_i        (timeout_w),
        .force_pulse_i  (state_q != LOCKED),
        .stable_o       (stable_w),
        .stable_valid_o (o_Stable_Valid),
        .commit_o       (commit_w)
    );

`ifdef ATTITUDE_LED_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF_PERIOD - 1);
    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NO_DATA: if (commit_w)  state_d = LOCKED;
            LOCKED:  if (timeout_w) state_d = STALE;
            STALE:   if (commit_w)  state_d = LOCKED;
            default:                state_d = NO_DATA;
        endcase

        if (i_Valid) begin
            timer_d = '0;
        end else if (timer_q == TMAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        led_d = led_map(stable_w);
`ifdef ATTITUDE_LED_BLINK_EN
        led_d[3:0] = led_d[3:0] & {4{phase_q}};
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= NO_DATA;
            timer_q <= '0;
            stale_q <= 1'b1;
            led_q   <= '0;
`ifdef ATTITUDE_LED_BLINK_EN
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            stale_q <= (state_d != LOCKED);
            led_q   <= (state_q == LOCKED) ? led_d : 5'b0;
`ifdef ATTITUDE_LED_BLINK_EN
            // Each fresh lock starts the blink with the LEDs on.
            if (state_q != LOCKED && state_d == LOCKED) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b1;
            end else if (blink_cnt_q == BMAX) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
`endif
        end
    end

    assign o_Attitude_Stable = stable_w;
    assign o_Stale           = stale_q;
    assign o_Led             = led_q;

endmodule

// File: tb/tb_attitude_led_driver.sv
module tb_attitude_led_driver;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 20;
    localparam int unsigned BH = 4;

`ifdef ATTITUDE_LED_BLINK_EN
    localparam logic [4:0] STEADY_MASK = 5'b10000;
`else
    localparam logic [4:0] STEADY_MASK = 5'b11111;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] att;
    logic       valid;
    logic [3:0] o_att;
    logic       o_sv;
    logic       o_stale;
    logic [4:0] o_led;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    attitude_led_driver #(
        .STABLE_SAMPLES(N),
        .SAMPLE_TIMEOUT(TO),
        .BLINK_HALF_PERIOD(BH)
    ) dut (
        .i_Clk             (clk),
        .i_Rst             (rst),
        .i_Attitude        (att),
        .i_Valid           (valid),
        .o_Attitude_Stable (o_att),
        .o_Stable_Valid    (o_sv),
        .o_Stale           (o_stale),
        .o_Led             (o_led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every commit pulse must match the next expected code.
    always @(negedge clk) begin
        if (o_sv === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got code %0h expected no pulse", o_att);
            end else begin
                chk("commit_value", {28'd0, o_att}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; presents one valid sample across the next posedge.
    task automatic send(input logic [3:0] a);
        att   = a;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        att   = 4'b0;
        valid = 1'b0;
        tick(3);
        chk("reset_stale", {31'd0, o_stale}, 32'd1);
        chk("reset_led",   {27'd0, o_led},   32'd0);
        chk("reset_code",  {28'd0, o_att},   32'd0);
        chk("reset_pulse", {31'd0, o_sv},    32'd0);
        rst = 1'b0;

        // 1: first lock on level
        send(4'b0000);
        send(4'b0000);
        chk("t1_not_yet_locked", {31'd0, o_stale}, 32'd1);
        exp_q.push_back(4'b0000);
        send(4'b0000);
        chk("t1_stale_cleared", {31'd0, o_stale}, 32'd0);
        tick(1);
        chk("t1_led_level", {27'd0, o_led}, {27'd0, 5'b10000});

        // 2: interrupted run only commits after three in a row
        send(4'b1010);
        send(4'b1010);
        send(4'b0110);
        send(4'b1010);
        send(4'b1010);
        chk("t2_held_before_run", {28'd0, o_att}, 32'd0);
        exp_q.push_back(4'b1010);
        send(4'b1010);
        chk("t2_code", {28'd0, o_att}, {28'd0, 4'b1010});
        tick(1);
        chk("t2_led_roll_neg", {27'd0, o_led & STEADY_MASK}, {27'd0, 5'b00100 & STEADY_MASK});

        // 3: signs without over-threshold mean level; saturated run is silent
        exp_q.push_back(4'b1100);
        send(4'b1100);
        send(4'b1100);
        send(4'b1100);
        tick(1);
        chk("t3_led_level", {27'd0, o_led & STEADY_MASK}, {27'd0, 5'b10000 & STEADY_MASK});
        send(4'b1100);
        chk("t3_code_held", {28'd0, o_att}, {28'd0, 4'b1100});

        // 4: valid on the timeout cycle wins, then a full idle timeout
        tick(TO - 1);
        chk("t4_before_timeout", {31'd0, o_stale}, 32'd0);
        send(4'b1100);
        chk("t4_valid_wins", {31'd0, o_stale}, 32'd0);
        tick(TO - 1);
        chk("t4_one_short", {31'd0, o_stale}, 32'd0);
        tick(1);
        chk("t4_stale", {31'd0, o_stale}, 32'd1);
        chk("t4_code_held", {28'd0, o_att}, {28'd0, 4'b1100});
        tick(1);
        chk("t4_led_dark", {27'd0, o_led}, 32'd0);

        // 5: reset mid-run discards candidate; fresh run required
        send(4'b0101);
        send(4'b0101);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_stale", {31'd0, o_stale}, 32'd1);
        chk("t5_rst_led",   {27'd0, o_led},   32'd0);
        chk("t5_rst_code",  {28'd0, o_att},   32'd0);
        chk("t5_rst_pulse", {31'd0, o_sv},    32'd0);
        send(4'b0101);
        chk("t5_after_1", {31'd0, o_stale}, 32'd1);
        send(4'b0101);
        chk("t5_after_2", {31'd0, o_stale}, 32'd1);
        exp_q.push_back(4'b0101);
        send(4'b0101);
        chk("t5_locked", {31'd0, o_stale}, 32'd0);
        tick(1);
        chk("t5_led_pitch_neg", {27'd0, o_led}, {27'd0, 5'b00001});

        // 7: same value recommitted after STALE still pulses
        tick(TO);
        chk("t7_stale", {31'd0, o_stale}, 32'd1);
        exp_q.push_back(4'b0101);
        send(4'b0101);
        send(4'b0101);
        send(4'b0101);
        chk("t7_relocked", {31'd0, o_stale}, 32'd0);

        // 6: lock on 0011; blink build toggles every BH clocks starting on
        do_reset();
        exp_q.push_back(4'b0011);
        send(4'b0011);
        send(4'b0011);
        send(4'b0011);
        for (int k = 1; k <= 2 * BH; k++) begin
            logic [4:0] e;
            tick(1);
            e = 5'b01010;
`ifdef ATTITUDE_LED_BLINK_EN
            if (k > BH) e = 5'b00000;
`endif
            chk("t6_led_phase", {27'd0, o_led}, {27'd0, e});
        end

        tick(2);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
